// File: rtl/ddr5_sched_pkg.sv
// Shared types for the DDR5 command sequencer: command/state encodings,
// default address-field widths and a default address-map struct.
package ddr5_sched_pkg;

  localparam int DEF_ROW_W  = 16;
  localparam int DEF_COLH_W = 6;
  localparam int DEF_BANK_W = 2;
  localparam int DEF_BG_W   = 3;
  localparam int DEF_CH_W   = 1;
  localparam int DEF_COLL_W = 4;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_PRE  = 3'd1,
    CMD_ACT0 = 3'd2,
    CMD_ACT1 = 3'd3,
    CMD_RD0  = 3'd4,
    CMD_RD1  = 3'd5,
    CMD_WR0  = 3'd6,
    CMD_WR1  = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_PRE      = 4'd1,
    ST_ACT0     = 4'd2,
    ST_ACT1     = 4'd3,
    ST_RW0      = 4'd4,
    ST_RW1      = 4'd5,
    ST_WAIT_ACT = 4'd6,
    ST_WAIT_RW  = 4'd7,
    ST_WAIT_PRE = 4'd8,
    ST_APRE     = 4'd9
  } state_e;

  // Address layout at default widths, MSB first.
  typedef struct packed {
    logic [DEF_ROW_W-1:0]  row;
    logic [DEF_COLH_W-1:0] col_high;
    logic [DEF_BANK_W-1:0] bank;
    logic [DEF_BG_W-1:0]   bg;
    logic [DEF_CH_W-1:0]   ch;
    logic [DEF_COLL_W-1:0] col_low;
    logic [1:0]            byte_off;
  } add_map_t;

  function automatic add_map_t map_default(input logic [33:0] addr);
    return add_map_t'(addr);
  endfunction

endpackage

// File: rtl/ddr5_bank_table.sv
// Per-bank open bit and open-row register; combinational lookup port and a
// synchronous set/clear port. Every bank is closed by reset.
module ddr5_bank_table #(
  parameter int IDX_W = 6,
  parameter int ROW_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] lk_idx_i,
  output logic             lk_open_o,
  output logic [ROW_W-1:0] lk_row_o,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             set_i,
  input  logic             clr_i,
  input  logic [ROW_W-1:0] set_row_i
);
  localparam int NB = 1 << IDX_W;

  logic [NB-1:0]    open_q;
  logic [ROW_W-1:0] row_q [NB];

  assign lk_open_o = open_q[lk_idx_i];
  assign lk_row_o  = row_q[lk_idx_i];

  // Open/close bookkeeping; set wins if both are requested.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      open_q <= '0;
      for (int i = 0; i < NB; i++) row_q[i] <= '0;
    end else if (set_i) begin
      open_q[wr_idx_i] <= 1'b1;
      row_q[wr_idx_i]  <= set_row_i;
    end else if (clr_i) begin
      open_q[wr_idx_i] <= 1'b0;
    end else begin
      open_q <= open_q;
    end
  end

endmodule

// File: rtl/ddr5_cmd_sequencer.sv
// Single-request DDR5 command sequencer: splits the address, tracks open rows
// and issues spaced PRE/ACT/RD/WR two-cycle sequences, open- or close-page.
module ddr5_cmd_sequencer
  import ddr5_sched_pkg::*;
#(
  parameter int ROW_W       = DEF_ROW_W,
  parameter int COLH_W      = DEF_COLH_W,
  parameter int BANK_W      = DEF_BANK_W,
  parameter int BG_W        = DEF_BG_W,
  parameter int CH_W        = DEF_CH_W,
  parameter int COLL_W      = DEF_COLL_W,
  parameter int PAGE_POLICY = 0,
  parameter int T_RP        = 2,
  parameter int T_RCD       = 4,
  parameter int T_RW2PRE    = 4,
  localparam int AW = (ROW_W > COLH_W + COLL_W) ? ROW_W : COLH_W + COLL_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [33:0]       req_addr_i,
  input  logic              req_write_i,
  output logic              cmd_valid_o,
  output logic [2:0]        cmd_o,
  output logic [CH_W-1:0]   cmd_ch_o,
  output logic [BG_W-1:0]   cmd_bg_o,
  output logic [BANK_W-1:0] cmd_bank_o,
  output logic [AW-1:0]     cmd_addr_o,
  output logic              req_done_o,
  output logic              row_hit_o
);
  localparam int COLL_LSB = 2;
  localparam int CH_LSB   = COLL_LSB + COLL_W;
  localparam int BG_LSB   = CH_LSB + CH_W;
  localparam int BANK_LSB = BG_LSB + BG_W;
  localparam int COLH_LSB = BANK_LSB + BANK_W;
  localparam int ROW_LSB  = COLH_LSB + COLH_W;
  localparam int IDX_W    = CH_W + BG_W + BANK_W;

  if (ROW_W + COLH_W + BANK_W + BG_W + CH_W + COLL_W != 32) begin : g_width_check
    $error("ddr5_cmd_sequencer: address field widths must total 32");
  end

  logic [ROW_W-1:0]  in_row_s, rq_row_q, tgt_row_s, lk_row_s;
  logic [COLH_W-1:0] in_colh_s, rq_colh_q, tgt_colh_s;
  logic [COLL_W-1:0] in_coll_s, rq_coll_q, tgt_coll_s;
  logic [BANK_W-1:0] in_bank_s, rq_bank_q, tgt_bank_s, bank_d, bank_q;
  logic [BG_W-1:0]   in_bg_s, rq_bg_q, tgt_bg_s, bg_d, bg_q;
  logic [CH_W-1:0]   in_ch_s, rq_ch_q, tgt_ch_s, ch_d, ch_q;
  logic              rq_write_q, tgt_write_s, accept_s, lk_open_s, hit_s;
  logic              tbl_set_s, tbl_clr_s, unused_s;
  logic              ready_q, valid_q, done_q, hit_q;
  logic [AW-1:0]     addr_d, addr_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  cmd_e              cmd_d, cmd_q;
  state_e            state_d, state_q;

  assign in_coll_s = req_addr_i[COLL_LSB +: COLL_W];
  assign in_ch_s   = req_addr_i[CH_LSB +: CH_W];
  assign in_bg_s   = req_addr_i[BG_LSB +: BG_W];
  assign in_bank_s = req_addr_i[BANK_LSB +: BANK_W];
  assign in_colh_s = req_addr_i[COLH_LSB +: COLH_W];
  assign in_row_s  = req_addr_i[ROW_LSB +: ROW_W];
  assign unused_s  = ^req_addr_i[1:0];

  assign accept_s = req_valid_i & ready_q;
  assign hit_s    = lk_open_s && (lk_row_s == in_row_s);

  // The output decode looks one state ahead, so on acceptance it must see the
  // incoming request rather than the not-yet-loaded request registers.
  assign tgt_row_s   = accept_s ? in_row_s    : rq_row_q;
  assign tgt_colh_s  = accept_s ? in_colh_s   : rq_colh_q;
  assign tgt_coll_s  = accept_s ? in_coll_s   : rq_coll_q;
  assign tgt_bank_s  = accept_s ? in_bank_s   : rq_bank_q;
  assign tgt_bg_s    = accept_s ? in_bg_s     : rq_bg_q;
  assign tgt_ch_s    = accept_s ? in_ch_s     : rq_ch_q;
  assign tgt_write_s = accept_s ? req_write_i : rq_write_q;

  ddr5_bank_table #(.IDX_W(IDX_W), .ROW_W(ROW_W)) u_bank_table (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .lk_idx_i  ({in_ch_s, in_bg_s, in_bank_s}),
    .lk_open_o (lk_open_s),
    .lk_row_o  (lk_row_s),
    .wr_idx_i  ({rq_ch_q, rq_bg_q, rq_bank_q}),
    .set_i     (tbl_set_s),
    .clr_i     (tbl_clr_s),
    .set_row_i (rq_row_q)
  );

  // Next-state, spacing counter and bank-table updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tbl_set_s = 1'b0;
    tbl_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!accept_s)       state_d = ST_IDLE;
        else if (!lk_open_s) state_d = ST_ACT0;
        else if (hit_s)      state_d = ST_RW0;
        else                 state_d = ST_PRE;
      end
      ST_PRE: begin
        tbl_clr_s = 1'b1;
        if (T_RP > 1) begin
          state_d = ST_WAIT_ACT;
          cnt_d   = CNT_W'(T_RP - 2);
        end else begin
          state_d = ST_ACT0;
        end
      end
      ST_WAIT_ACT: begin
        if (cnt_q == '0) state_d = ST_ACT0;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ACT0: state_d = ST_ACT1;
      ST_ACT1: begin
        tbl_set_s = 1'b1;
        if (T_RCD > 2) begin
          state_d = ST_WAIT_RW;
          cnt_d   = CNT_W'(T_RCD - 3);
        end else begin
          state_d = ST_RW0;
        end
      end
      ST_WAIT_RW: begin
        if (cnt_q == '0) state_d = ST_RW0;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RW0: state_d = ST_RW1;
      ST_RW1: begin
        if (PAGE_POLICY == 0) begin
          state_d = ST_IDLE;
        end else if (T_RW2PRE > 2) begin
          state_d = ST_WAIT_PRE;
          cnt_d   = CNT_W'(T_RW2PRE - 3);
        end else begin
          state_d = ST_APRE;
        end
      end
      ST_WAIT_PRE: begin
        if (cnt_q == '0) state_d = ST_APRE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_APRE: begin
        tbl_clr_s = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command decode for the state about to be entered; registered below.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    case (state_d)
      ST_PRE, ST_APRE: cmd_d = CMD_PRE;
      ST_ACT0: begin cmd_d = CMD_ACT0; addr_d = AW'(tgt_row_s); end
      ST_ACT1: begin cmd_d = CMD_ACT1; addr_d = AW'(tgt_row_s); end
      ST_RW0: begin
        cmd_d  = tgt_write_s ? CMD_WR0 : CMD_RD0;
        addr_d = AW'({tgt_colh_s, tgt_coll_s});
      end
      ST_RW1: begin
        cmd_d  = tgt_write_s ? CMD_WR1 : CMD_RD1;
        addr_d = AW'({tgt_colh_s, tgt_coll_s});
      end
      default: cmd_d = CMD_NOP;
    endcase
    if (cmd_d != CMD_NOP) begin
      ch_d   = tgt_ch_s;
      bg_d   = tgt_bg_s;
      bank_d = tgt_bank_s;
    end else begin
      ch_d   = '0;
      bg_d   = '0;
      bank_d = '0;
    end
  end

  // State, request capture and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rq_row_q   <= '0;
      rq_colh_q  <= '0;
      rq_coll_q  <= '0;
      rq_bank_q  <= '0;
      rq_bg_q    <= '0;
      rq_ch_q    <= '0;
      rq_write_q <= 1'b0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      cmd_q      <= CMD_NOP;
      addr_q     <= '0;
      ch_q       <= '0;
      bg_q       <= '0;
      bank_q     <= '0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_s) begin
        rq_row_q   <= in_row_s;
        rq_colh_q  <= in_colh_s;
        rq_coll_q  <= in_coll_s;
        rq_bank_q  <= in_bank_s;
        rq_bg_q    <= in_bg_s;
        rq_ch_q    <= in_ch_s;
        rq_write_q <= req_write_i;
      end else begin
        rq_write_q <= rq_write_q;
      end
      ready_q <= (state_d == ST_IDLE);
      valid_q <= (cmd_d != CMD_NOP);
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ch_q    <= ch_d;
      bg_q    <= bg_d;
      bank_q  <= bank_d;
      done_q  <= (state_d == ST_RW1);
      hit_q   <= accept_s & hit_s;
    end
  end

  assign req_ready_o = ready_q;
  assign cmd_valid_o = valid_q;
  assign cmd_o       = cmd_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_ch_o    = ch_q;
  assign cmd_bg_o    = bg_q;
  assign cmd_bank_o  = bank_q;
  assign req_done_o  = done_q;
  assign row_hit_o   = hit_q;

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Directed bench: an open-page and a close-page sequencer, table-driven request
// vectors with per-cycle command strings, plus hold-valid and mid-sequence reset.
module tb_ddr5_cmd_sequencer;
  localparam int NC = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0, sel = 1'b0;
  logic [33:0] req_addr = '0;

  logic o_ready, o_valid, o_done, o_hit, o_ch;
  logic c_ready, c_valid, c_done, c_hit, c_ch;
  logic [2:0]  o_cmd, c_cmd, o_bg, c_bg;
  logic [1:0]  o_bank, c_bank;
  logic [15:0] o_addr, c_addr;

  ddr5_cmd_sequencer #(.PAGE_POLICY(0)) dut_open (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid & ~sel), .req_ready_o(o_ready),
    .req_addr_i(req_addr), .req_write_i(req_write), .cmd_valid_o(o_valid), .cmd_o(o_cmd),
    .cmd_ch_o(o_ch), .cmd_bg_o(o_bg), .cmd_bank_o(o_bank), .cmd_addr_o(o_addr),
    .req_done_o(o_done), .row_hit_o(o_hit));

  ddr5_cmd_sequencer #(.PAGE_POLICY(1)) dut_close (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid & sel), .req_ready_o(c_ready),
    .req_addr_i(req_addr), .req_write_i(req_write), .cmd_valid_o(c_valid), .cmd_o(c_cmd),
    .cmd_ch_o(c_ch), .cmd_bg_o(c_bg), .cmd_bank_o(c_bank), .cmd_addr_o(c_addr),
    .req_done_o(c_done), .row_hit_o(c_hit));

  logic s_ready, s_valid, s_done, s_hit;
  logic [2:0]  s_cmd;
  logic [5:0]  s_tgt;
  logic [15:0] s_addr;
  assign s_ready = sel ? c_ready : o_ready;
  assign s_valid = sel ? c_valid : o_valid;
  assign s_done  = sel ? c_done  : o_done;
  assign s_hit   = sel ? c_hit   : o_hit;
  assign s_cmd   = sel ? c_cmd   : o_cmd;
  assign s_tgt   = sel ? {c_ch, c_bg, c_bank} : {o_ch, o_bg, o_bank};
  assign s_addr  = sel ? c_addr  : o_addr;

  typedef struct {
    logic        sel;
    logic [15:0] row;
    logic [5:0]  colh;
    logic [1:0]  bank;
    logic [2:0]  bg;
    logic        ch;
    logic [3:0]  coll;
    logic        wr;
    logic        hit;
    string       seq;   // cycles 1..12: . P A a R r W w
  } vec_t;

  vec_t vt [11];
  int checks = 0, failures = 0;

  logic [2:0]  lg_cmd   [1:NC];
  logic [15:0] lg_addr  [1:NC];
  logic [5:0]  lg_tgt   [1:NC];
  logic        lg_valid [1:NC];
  logic        lg_done  [1:NC];
  logic        lg_hit   [1:NC];
  logic        lg_ready [1:NC];

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] mk_addr(input vec_t v);
    return {v.row, v.colh, v.bank, v.bg, v.ch, v.coll, 2'b11};
  endfunction

  function automatic logic [2:0] cmd_of(input byte c);
    case (c)
      "P": return 3'd1;
      "A": return 3'd2;
      "a": return 3'd3;
      "R": return 3'd4;
      "r": return 3'd5;
      "W": return 3'd6;
      "w": return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  task automatic issue(input vec_t v, input logic hold);
    int n = 0;
    sel = v.sel;
    #0;
    while (s_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("ready_timeout", {33'd0, s_ready}, 34'd1);
    req_addr  = mk_addr(v);
    req_write = v.wr;
    req_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= NC; c++) begin
      lg_cmd[c] = s_cmd;  lg_addr[c] = s_addr; lg_tgt[c] = s_tgt; lg_valid[c] = s_valid;
      lg_done[c] = s_done; lg_hit[c] = s_hit;  lg_ready[c] = s_ready;
      if (hold && s_ready !== 1'b1) begin
        req_addr  = {16'(7 + c), 6'd1, 2'd1, 3'd1, 1'b0, 4'd1, 2'b00};
        req_write = ~req_write;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_run(input vec_t v, input string tag);
    int last = 0;
    for (int c = 1; c <= NC; c++) if (v.seq[c-1] != ".") last = c;
    for (int c = 1; c <= NC; c++) begin
      byte         ch   = v.seq[c-1];
      logic [2:0]  ecmd = cmd_of(ch);
      logic [15:0] ea   = 16'd0;
      logic [5:0]  et   = (ecmd != 3'd0) ? {v.ch, v.bg, v.bank} : 6'd0;
      if (ch == "A" || ch == "a") ea = v.row;
      else if (ecmd >= 3'd4)      ea = {6'd0, v.colh, v.coll};
      else                        ea = 16'd0;
      chk($sformatf("%s c%0d cmd", tag, c),   {31'd0, lg_cmd[c]}, {31'd0, ecmd});
      chk($sformatf("%s c%0d valid", tag, c), {33'd0, lg_valid[c]}, {33'd0, ecmd != 3'd0});
      chk($sformatf("%s c%0d addr", tag, c),  {18'd0, lg_addr[c]}, {18'd0, ea});
      chk($sformatf("%s c%0d tgt", tag, c),   {28'd0, lg_tgt[c]}, {28'd0, et});
      chk($sformatf("%s c%0d done", tag, c),  {33'd0, lg_done[c]}, {33'd0, ch == "r" || ch == "w"});
      chk($sformatf("%s c%0d ready", tag, c), {33'd0, lg_ready[c]}, {33'd0, c > last});
    end
    chk($sformatf("%s row_hit c1", tag), {33'd0, lg_hit[1]}, {33'd0, v.hit});
    chk($sformatf("%s row_hit c2", tag), {33'd0, lg_hit[2]}, 34'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " o_ready"}, {33'd0, o_ready}, 34'd1);
    chk({tag, " o_valid"}, {33'd0, o_valid}, 34'd0);
    chk({tag, " o_cmd"},   {31'd0, o_cmd}, 34'd0);
    chk({tag, " o_fields"}, {12'd0, o_ch, o_bg, o_bank, o_addr}, 34'd0);
    chk({tag, " o_done_hit"}, {32'd0, o_done, o_hit}, 34'd0);
    chk({tag, " c_ready"}, {33'd0, c_ready}, 34'd1);
    chk({tag, " c_valid"}, {33'd0, c_valid}, 34'd0);
    chk({tag, " c_cmd"},   {31'd0, c_cmd}, 34'd0);
    chk({tag, " c_fields"}, {12'd0, c_ch, c_bg, c_bank, c_addr}, 34'd0);
    chk({tag, " c_done_hit"}, {32'd0, c_done, c_hit}, 34'd0);
  endtask

  initial begin
    vt[0]  = '{1'b0, 16'd1,      6'd0,  2'd0, 3'd0, 1'b0, 4'd0,  1'b0, 1'b0, "Aa..Rr......"};
    vt[1]  = '{1'b0, 16'd1,      6'd0,  2'd0, 3'd0, 1'b0, 4'd0,  1'b1, 1'b1, "Ww.........."};
    vt[2]  = '{1'b0, 16'd2,      6'd0,  2'd0, 3'd0, 1'b0, 4'd0,  1'b0, 1'b0, "P.Aa..Rr...."};
    vt[3]  = '{1'b0, 16'h1234,   6'h2A, 2'd2, 3'd5, 1'b1, 4'd9,  1'b1, 1'b0, "Aa..Ww......"};
    vt[4]  = '{1'b0, 16'h1234,   6'h2A, 2'd2, 3'd5, 1'b1, 4'd9,  1'b0, 1'b1, "Rr.........."};
    vt[5]  = '{1'b0, 16'd2,      6'd3,  2'd0, 3'd0, 1'b0, 4'd15, 1'b0, 1'b1, "Rr.........."};
    vt[6]  = '{1'b1, 16'd1,      6'd0,  2'd0, 3'd0, 1'b0, 4'd0,  1'b0, 1'b0, "Aa..Rr..P..."};
    vt[7]  = '{1'b1, 16'd1,      6'd0,  2'd0, 3'd0, 1'b0, 4'd0,  1'b0, 1'b0, "Aa..Rr..P..."};
    vt[8]  = '{1'b1, 16'hABCD,   6'd1,  2'd3, 3'd7, 1'b1, 4'd2,  1'b1, 1'b0, "Aa..Ww..P..."};
    vt[9]  = '{1'b0, 16'd5,      6'd4,  2'd3, 3'd2, 1'b0, 4'd6,  1'b0, 1'b0, "Aa..Rr......"};
    vt[10] = '{1'b0, 16'd7,      6'd1,  2'd1, 3'd1, 1'b0, 4'd1,  1'b0, 1'b0, "Aa..Rr......"};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_idle_outputs("reset");

    for (int i = 0; i <= 8; i++) begin
      issue(vt[i], 1'b0);
      check_run(vt[i], $sformatf("vec%0d", i));
    end

    // Valid held high with a changing address while busy.
    issue(vt[9], 1'b1);
    check_run(vt[9], "hold");
    issue(vt[10], 1'b0);
    check_run(vt[10], "hold_side_effect");

    // Reset while waiting for tRCD.
    sel       = 1'b0;
    req_addr  = {16'd9, 6'd0, 2'd0, 3'd2, 1'b0, 4'd0, 2'b00};
    req_write = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_seq ACT0", {31'd0, o_cmd}, 34'd2);
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_seq busy", {33'd0, o_ready}, 34'd0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("post_rst c%0d quiet", c), {31'd0, o_ready, o_valid, o_done}, 34'd4);
      @(posedge clk); #1;
    end
    vt[9] = '{1'b0, 16'd9, 6'd0, 2'd0, 3'd2, 1'b0, 4'd0, 1'b0, 1'b0, "Aa..Rr......"};
    issue(vt[9], 1'b0);
    check_run(vt[9], "post_rst_same_row");
    vt[5].hit = 1'b0;
    vt[5].seq = "Aa..Rr......";
    issue(vt[5], 1'b0);
    check_run(vt[5], "post_rst_bank0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
